// File: rtl/axis_burst_decimator.sv
// axis_burst_decimator
// Triggered accumulate-and-dump decimator. A rising trigger edge starts a
// capture of a programmed number of output words. Each word is the wrapped
// sum of a programmed number of consecutive signed input samples. Words are
// presented on an AXI4-Stream master port. The input is never stalled: a
// word that finds the output register occupied is dropped and flagged.
module axis_burst_decimator #(
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH         = 32,
    parameter int DEC_WIDTH          = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [CNTR_WIDTH-1:0]         cfg_length,
    input  logic [DEC_WIDTH-1:0]          cfg_decim,
    input  logic                          trigger,
    output logic                          busy,
    output logic                          overflow,
    output logic [CNTR_WIDTH-1:0]         sts_count,
    output logic                          s_axis_tready,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                        state_reg;
    logic                          trig_q;
    logic                          tready_reg;
    logic                          busy_reg;
    logic                          overflow_reg;
    logic [CNTR_WIDTH-1:0]         len_reg;
    logic [CNTR_WIDTH-1:0]         count_reg;
    logic [DEC_WIDTH-1:0]          decim_reg;
    logic [DEC_WIDTH-1:0]          sample_cnt_reg;
    logic [M_AXIS_TDATA_WIDTH-1:0] acc_reg;
    logic [M_AXIS_TDATA_WIDTH-1:0] tdata_reg;
    logic                          tvalid_reg;

    logic [M_AXIS_TDATA_WIDTH-1:0] sample_ext;
    logic [M_AXIS_TDATA_WIDTH-1:0] acc_next;
    logic [DEC_WIDTH-1:0]          sample_cnt_next;
    logic [CNTR_WIDTH-1:0]         count_next;
    logic [DEC_WIDTH-1:0]          decim_eff;
    logic                          trig_edge;
    logic                          word_done;
    logic                          out_free;

    // Sign-extend the input sample bit by bit to the accumulator width;
    // works unchanged when both widths are equal.
    genvar gi;
    generate
        for (gi = 0; gi < M_AXIS_TDATA_WIDTH; gi++) begin : g_sext
            if (gi < S_AXIS_TDATA_WIDTH) begin : g_copy
                assign sample_ext[gi] = s_axis_tdata[gi];
            end else begin : g_sign
                assign sample_ext[gi] = s_axis_tdata[S_AXIS_TDATA_WIDTH-1];
            end
        end
    endgenerate

    // Datapath helpers: running sum, counters, edge detect and output-slot status.
    always_comb begin
        acc_next        = acc_reg + sample_ext;
        sample_cnt_next = sample_cnt_reg + 1'b1;
        count_next      = count_reg + 1'b1;
        decim_eff       = (cfg_decim == '0) ? {{(DEC_WIDTH-1){1'b0}}, 1'b1} : cfg_decim;
        trig_edge       = trigger & ~trig_q;
        word_done       = (sample_cnt_next == decim_reg);
        // Slot can take a new word when empty or being emptied this cycle.
        out_free        = ~tvalid_reg | m_axis_tready;
    end

    // Control FSM plus accumulator, counters and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            trig_q         <= 1'b0;
            tready_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            len_reg        <= '0;
            count_reg      <= '0;
            decim_reg      <= '0;
            sample_cnt_reg <= '0;
            acc_reg        <= '0;
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
        end else begin
            tready_reg <= 1'b1;
            trig_q     <= trigger;

            // An accepted word empties the slot unless a new word refills it below.
            if (tvalid_reg && m_axis_tready) begin
                tvalid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (trig_edge && (cfg_length != '0)) begin
                        state_reg      <= ST_CAPTURE;
                        busy_reg       <= 1'b1;
                        len_reg        <= cfg_length;
                        decim_reg      <= decim_eff;
                        acc_reg        <= '0;
                        sample_cnt_reg <= '0;
                        count_reg      <= '0;
                        overflow_reg   <= 1'b0;
                    end
                end

                ST_CAPTURE: begin
                    if (s_axis_tvalid) begin
                        if (word_done) begin
                            acc_reg        <= '0;
                            sample_cnt_reg <= '0;
                            count_reg      <= count_next;
                            if (out_free) begin
                                tvalid_reg <= 1'b1;
                                tdata_reg  <= acc_next;
                            end else begin
                                overflow_reg <= 1'b1;
                            end
                            if (count_next == len_reg) begin
                                state_reg <= ST_DRAIN;
                            end
                        end else begin
                            acc_reg        <= acc_next;
                            sample_cnt_reg <= sample_cnt_next;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (out_free) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_reg;
    assign busy          = busy_reg;
    assign overflow      = overflow_reg;
    assign sts_count     = count_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;

endmodule

// File: tb/tb_axis_burst_decimator.sv
// tb_axis_burst_decimator
// Directed plus randomized checks of axis_burst_decimator against a
// cycle-level behavioural model; a second instance with a 16-bit output
// exercises wrap-around at the narrower width.
module tb_axis_burst_decimator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_length;
    logic [15:0] cfg_decim;
    logic        trigger;
    logic        busy, overflow;
    logic [31:0] sts_count;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;

    logic        busy2, overflow2, s_axis_tready2, m_axis_tvalid2;
    logic [31:0] sts_count2;
    logic [15:0] m_axis_tdata2;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int          md_mode;      // 0 idle, 1 capturing, 2 waiting for last word to leave
    logic        md_trig;
    logic        md_tready;
    logic        md_valid;
    logic [31:0] md_data;
    logic [31:0] md_sum;
    int          md_n, md_dec;
    logic [31:0] md_len, md_words;
    logic        md_ovf;
    int          md_accepts;

    logic [31:0] got[$];
    logic [15:0] got16[$];

    always #5 aclk = ~aclk;

    axis_burst_decimator #(
        .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .DEC_WIDTH(16)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_length(cfg_length), .cfg_decim(cfg_decim),
        .trigger(trigger), .busy(busy), .overflow(overflow), .sts_count(sts_count),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid)
    );

    axis_burst_decimator #(
        .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(16), .CNTR_WIDTH(32), .DEC_WIDTH(16)
    ) u_dut16 (
        .aclk(aclk), .aresetn(aresetn), .cfg_length(cfg_length), .cfg_decim(cfg_decim),
        .trigger(trigger), .busy(busy2), .overflow(overflow2), .sts_count(sts_count2),
        .s_axis_tready(s_axis_tready2), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata2), .m_axis_tvalid(m_axis_tvalid2)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_mode = 0; md_trig = 1'b0; md_tready = 1'b0; md_valid = 1'b0; md_data = '0;
        md_sum = '0; md_n = 0; md_dec = 1; md_len = '0; md_words = '0; md_ovf = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic        edge_t, acc_t, res;
        logic [31:0] word;
        if (!aresetn) begin
            model_reset();
            return;
        end
        md_tready = 1'b1;
        edge_t    = trigger && !md_trig;
        md_trig   = trigger;
        acc_t     = md_valid && m_axis_tready;
        if (acc_t) md_accepts++;
        res  = 1'b0;
        word = '0;
        case (md_mode)
            0: begin
                if (acc_t) md_valid = 1'b0;
                if (edge_t && cfg_length != 0) begin
                    md_mode = 1; md_len = cfg_length;
                    md_dec = (cfg_decim == 0) ? 1 : int'(cfg_decim);
                    md_sum = '0; md_n = 0; md_words = '0; md_ovf = 1'b0;
                end
            end
            1: begin
                if (s_axis_tvalid) begin
                    md_sum = md_sum + 32'($signed(s_axis_tdata));
                    md_n++;
                    if (md_n == md_dec) begin
                        res = 1'b1; word = md_sum; md_sum = '0; md_n = 0; md_words++;
                    end
                end
                if (res && (!md_valid || acc_t)) begin
                    md_valid = 1'b1; md_data = word;
                end else if (res) begin
                    md_ovf = 1'b1;
                end else if (acc_t) begin
                    md_valid = 1'b0;
                end
                if (md_words == md_len) md_mode = 2;
            end
            default: begin
                if (!md_valid || acc_t) md_mode = 0;
                if (acc_t) md_valid = 1'b0;
            end
        endcase
    endtask

    task automatic compare();
        check("tready", {31'd0, s_axis_tready}, {31'd0, md_tready});
        check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, md_valid});
        if (md_valid) check("tdata", m_axis_tdata, md_data);
        check("busy", {31'd0, busy}, {31'd0, md_mode != 0});
        check("overflow", {31'd0, overflow}, {31'd0, md_ovf});
        check("sts_count", sts_count, md_words);
        check("tvalid16", {31'd0, m_axis_tvalid2}, {31'd0, md_valid});
        if (md_valid) check("tdata16", {16'd0, m_axis_tdata2}, {16'd0, md_data[15:0]});
        check("busy16", {31'd0, busy2}, {31'd0, md_mode != 0});
    endtask

    // One clock: record handshakes, let the edge happen, update model, compare.
    task automatic step();
        if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        if (m_axis_tvalid2 && m_axis_tready) got16.push_back(m_axis_tdata2);
        @(posedge aclk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic fire(logic [31:0] len, logic [15:0] dec);
        cfg_length = len; cfg_decim = dec; trigger = 1'b1;
        got.delete(); got16.delete(); md_accepts = 0;
        step();
        trigger = 1'b0;
    endtask

    task automatic run_idle(int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        aresetn = 1'b1; trigger = 1'b0; cfg_length = '0; cfg_decim = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1; md_accepts = 0;
        model_reset();
        #2 aresetn = 1'b0;
        #1 compare();
        step(); step();
        aresetn = 1'b1;
        step();
        check("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

        // Basic capture: length 4, decim 2, samples 1,2,3,...
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'd99;
        fire(32'd4, 16'd2);
        for (int i = 1; i <= 8; i++) begin s_axis_tdata = 16'(i); step(); end
        s_axis_tvalid = 1'b0;
        run_idle(20);
        check("basic_n", got.size(), 32'd4);
        check("basic_w0", got[0], 32'd3);
        check("basic_w1", got[1], 32'd7);
        check("basic_w2", got[2], 32'd11);
        check("basic_w3", got[3], 32'd15);
        check("basic_sts", sts_count, 32'd4);
        check("basic_ovf", {31'd0, overflow}, 32'd0);

        // Sign extension: three times -32768 summed at 32 bits
        fire(32'd1, 16'd3);
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h8000;
        repeat (3) step();
        s_axis_tvalid = 1'b0;
        run_idle(20);
        check("sign_w", got[0], 32'hFFFE8000);

        // Wrap: 0x7FFF + 0x0001 overflows the 16-bit instance to 0x8000
        fire(32'd1, 16'd2);
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h7FFF; step();
        s_axis_tdata = 16'h0001; step();
        s_axis_tvalid = 1'b0;
        run_idle(20);
        check("wrap32_w", got[0], 32'h00008000);
        check("wrap16_w", {16'd0, got16[0]}, 32'h00008000);

        // Back-pressure: first word held, next two dropped
        m_axis_tready = 1'b0;
        fire(32'd3, 16'd1);
        s_axis_tvalid = 1'b1;
        for (int i = 5; i <= 7; i++) begin s_axis_tdata = 16'(i); step(); end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        run_idle(20);
        check("bp_n", got.size(), 32'd1);
        check("bp_w0", got[0], 32'd5);
        check("bp_ovf", {31'd0, overflow}, 32'd1);
        check("bp_sts", sts_count, 32'd3);

        // Results land exactly on accept cycles: no drops
        fire(32'd8, 16'd1);
        for (int i = 0; i < 16; i++) begin
            m_axis_tready = (i % 2 == 0); s_axis_tvalid = m_axis_tready;
            s_axis_tdata = 16'(10 + i / 2);
            step();
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        run_idle(20);
        check("tog_n", got.size(), 32'd8);
        for (int k = 0; k < 8; k++) check($sformatf("tog_w%0d", k), got[k], 32'(10 + k));
        check("tog_ovf", {31'd0, overflow}, 32'd0);

        // Zero length: trigger ignored
        fire(32'd0, 16'd1);
        repeat (3) step();
        check("len0_busy", {31'd0, busy}, 32'd0);

        // Trigger held high: one capture only
        cfg_length = 32'd2; cfg_decim = 16'd1; trigger = 1'b1;
        got.delete(); s_axis_tvalid = 1'b1; s_axis_tdata = 16'd3;
        repeat (10) step();
        check("held_n", got.size(), 32'd2);
        check("held_busy", {31'd0, busy}, 32'd0);
        trigger = 1'b0; s_axis_tvalid = 1'b0; step();

        // Re-trigger and cfg change during capture are ignored
        fire(32'd3, 16'd2);
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'd1;
        step(); step();
        trigger = 1'b1; cfg_length = 32'd7; step();
        trigger = 1'b0;
        repeat (3) step();
        s_axis_tvalid = 1'b0;
        run_idle(20);
        check("retrig_sts", sts_count, 32'd3);
        check("retrig_n", got.size(), 32'd3);

        // Reset after two of five words
        fire(32'd5, 16'd1);
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'd1; step();
        s_axis_tdata = 16'd2; step();
        aresetn = 1'b0; model_reset();
        #1 compare();
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_sts", sts_count, 32'd0);
        step(); step();
        aresetn = 1'b1; s_axis_tvalid = 1'b0;
        step();
        fire(32'd5, 16'd1);
        s_axis_tvalid = 1'b1;
        for (int i = 20; i < 25; i++) begin s_axis_tdata = 16'(i); step(); end
        s_axis_tvalid = 1'b0;
        run_idle(20);
        check("rst_n", got.size(), 32'd5);
        for (int k = 0; k < 5; k++) check($sformatf("rst_w%0d", k), got[k], 32'(20 + k));

        // Randomized captures against the model
        for (int c = 0; c < 8; c++) begin
            fire(32'($urandom_range(1, 6)), 16'($urandom_range(0, 3)));
            for (int i = 0; i < 40; i++) begin
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                m_axis_tready = ($urandom_range(0, 9) < 7);
                s_axis_tdata  = 16'($urandom);
                step();
            end
            s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
            run_idle(100);
            check("rand_delivered", got.size(), 32'(md_accepts));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_burst_decimator.md
# axis_burst_decimator

Triggered acquisition stage that sits directly upstream of the AXI4-Stream FIFO adapter in the receive path. It takes the free-running signed ADC sample stream, and on a trigger edge captures a programmed number of output words. Each word is the sum of `cfg_decim` consecutive input samples (accumulate-and-dump decimation). It presents the words on an AXI4-Stream master port that feeds the FIFO's slave side. The ADC source is never back-pressured; loss of output words is reported rather than stalled.

## Interface
- `S_AXIS_TDATA_WIDTH`, 16: input sample width, two's complement.
- `M_AXIS_TDATA_WIDTH`, 32: output word / accumulator width. Must be ≥ `S_AXIS_TDATA_WIDTH`.
- `CNTR_WIDTH`, 32: width of the length and word counters.
- `DEC_WIDTH`, 16: width of the decimation factor.

Ports:
- `aclk`  in  1  the single clock; all logic is on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `cfg_length`  in  CNTR_WIDTH  number of output words per capture.
- `cfg_decim`  in  DEC_WIDTH  input samples summed per output word; 0 is treated as 1.
- `trigger`  in  1  capture start; acts on the rising edge only.
- `busy`  out  1  high in the CAPTURE and DRAIN states.
- `overflow`  out  1  sticky flag: at least one output word was dropped in the current capture.
- `sts_count`  out  CNTR_WIDTH  output words produced (kept or dropped) in the current or last capture.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tdata`  in  S_AXIS_TDATA_WIDTH  input sample.
- `s_axis_tvalid`  in  1  input valid.
- `m_axis_tready`  in  1  output ready, driven by the FIFO adapter.
- `m_axis_tdata`  out  M_AXIS_TDATA_WIDTH  output word.
- `m_axis_tvalid`  out  1  output valid.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- `s_axis_tready` is constant 1 in every state after reset. In IDLE and DRAIN, samples are consumed and discarded.
- Trigger edge detect: a `trig_q` register holds the previous value of `trigger`. An edge is `trigger & ~trig_q`.
- IDLE → CAPTURE on an edge when `cfg_length != 0`. At that edge:
  - latch `cfg_length` and `cfg_decim`;
  - clear the accumulator, the sample counter, `sts_count` and `overflow`.
- An edge while `cfg_length == 0` is ignored. An edge in CAPTURE or DRAIN is ignored.
- `cfg_*` changes after the latch have no effect until the next capture.
- In CAPTURE, each `s_axis_tvalid` beat is processed as follows:
  - the sample is sign-extended to M_AXIS_TDATA_WIDTH and added to the accumulator;
  - the sample counter increments;
  - on the D-th sample (D = latched decim, min 1) the complete sum, including that sample, is a result;
  - the accumulator restarts from 0 on the next sample;
  - `sts_count` increments by 1.
- Arithmetic: the sum wraps modulo 2^M_AXIS_TDATA_WIDTH. There is no saturation.
- Output register handling when a result is produced:
  - if the register is empty, or is being accepted this cycle (`m_axis_tvalid & m_axis_tready`), the result loads it;
  - otherwise the result is dropped, the register keeps its old word, and `overflow` sets.
- CAPTURE → DRAIN when `sts_count` reaches the latched length.
- DRAIN → IDLE once the output register is empty. `busy` falls on the same edge.
- Reset mid-operation clears everything immediately. The pending output word is lost.

## Timing
- Reset values:
  - `s_axis_tready` = 0 while `aresetn` is low, and 1 from the first clock edge after release;
  - `m_axis_tvalid`, `m_axis_tdata`, `busy`, `overflow`, `sts_count` = 0;
  - state = IDLE, `trig_q` = 0.
- Trigger latency: the edge is detected at clock edge k, and the state is CAPTURE after k. The first sample summed is the one with `tvalid` at edge k+1.
- Result latency: a word completing at edge j drives `m_axis_tvalid` = 1 and `m_axis_tdata` after edge j (one cycle).
- Output handshake: `m_axis_tdata` stays stable while `m_axis_tvalid` is high and `tready` is low. `tvalid` is never withdrawn without acceptance.
- Full rate: with D = 1, continuous valid input, and `m_axis_tready` held at 1, one word is produced per cycle with no drops.
- `sts_count` and `overflow` update on the same edge as the result.

## Test plan
- Basic capture: `cfg_length`=4, `cfg_decim`=2, samples 1,2,3,…, `tready`=1.
  - Output is 3, 7, 11, 15.
  - `busy` falls after the last accept; `sts_count`=4; `overflow`=0.
- Sign and wrap: S=16, M=32, D=3, samples −32768 ×3 → word 0xFFFE8000. With M=16 and samples 0x7FFF, 0x0001 (D=2) → 0x8000.
- Back-pressure: D=1, length 3, `tready`=0 for 3 cycles, then 1.
  - First word is held stable; the other 2 are dropped.
  - `overflow`=1, `sts_count`=3, exactly one word is delivered, then IDLE.
- Simultaneous accept and new result: D=1, `tready` toggling each cycle starting high.
  - A new result arriving in the same cycle as an accept loads without overflow.
  - All 8 words of a length-8 capture match, given input held so results align with accepts.
- Trigger rules:
  - `cfg_length`=0 plus a trigger edge → `busy` stays 0.
  - Trigger held high → only one capture.
  - Re-trigger during CAPTURE → ignored; `sts_count` ends at `cfg_length`.
- Reset mid-capture: drop `aresetn` after 2 of 5 words.
  - All outputs are 0 immediately.
  - After release, a new trigger captures 5 fresh words starting from a zero accumulator.
